// File: rtl/piso_pkg.sv
// Shared types for the PISO serializer: FSM state encoding and the
// bit-counter width derivation used by the top level.
package piso_pkg;

   // PARITY is only reachable when the design is built with PISO_PARITY_EN.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   // Smallest counter width able to index WIDTH bits (equivalent to $clog2, minimum 1).
   function automatic int cnt_width(input int width);
      int w = 1;
      while ((1 << w) < width) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit parallel-load, shift-left register. The msb output is the bit
// currently presented on the serial line; load has priority over shift.
module piso_shift_reg
   import piso_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             msb
);

   logic [WIDTH-1:0] sreg;

   // Capture a new word on load, otherwise move the next bit into the MSB position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sreg <= '0;
      else if (load)
         sreg <= din;
      else if (shift)
         sreg <= {sreg[WIDTH-2:0], 1'b0};
   end

   assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter, MSB first, with a valid/ready word
// interface. Build option: define PISO_PARITY_EN to append an even-parity
// bit after each word (frame = WIDTH+1 cycles); without it a frame is WIDTH
// cycles. load_ready is also raised on the final bit of a frame so that
// consecutive words stream with no idle cycle between them.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             q,
   output logic             q_valid,
   output logic             done
);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             last_data;
   logic             frame_end;
   logic             shift_msb;
   logic             parity_bit;

   assign accept    = load_valid & load_ready;
   assign last_data = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));

`ifdef PISO_PARITY_EN
   assign frame_end = (state == PARITY);

   // Even parity of the accepted word, held until its parity cycle.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
         parity_bit <= 1'b0;
      else if (accept)
         parity_bit <= ^load_data;
   end
`else
   assign frame_end  = last_data;
   assign parity_bit = 1'b0;
`endif

   piso_shift_reg #(
      .WIDTH (WIDTH)
   ) u_shift_reg (
      .clk   (Clock),
      .rst   (Reset),
      .load  (accept),
      .shift (state == SHIFT),
      .din   (load_data),
      .msb   (shift_msb)
   );

   // State register.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Bit counter: restarts on every accepted word, stops at WIDTH-1.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
         cnt <= '0;
      else if (accept || last_data)
         cnt <= '0;
      else if (state == SHIFT)
         cnt <= cnt + CNT_W'(1);
   end

   // Next-state logic; an accept on the frame's final cycle chains straight into SHIFT.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept)
               state_nxt = SHIFT;
         end
         SHIFT: begin
            if (last_data) begin
`ifdef PISO_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = accept ? SHIFT : IDLE;
`endif
            end
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            state_nxt = accept ? SHIFT : IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode; everything is zero in IDLE except load_ready.
   always_comb begin
      q          = 1'b0;
      q_valid    = 1'b0;
      done       = frame_end;
      load_ready = (state == IDLE) | frame_end;
      case (state)
         SHIFT: begin
            q       = shift_msb;
            q_valid = 1'b1;
         end
         PARITY: begin
            q       = parity_bit;
            q_valid = 1'b1;
         end
         default: begin
            q       = 1'b0;
            q_valid = 1'b0;
         end
      endcase
   end

endmodule
